// File: rtl/axi_slave_mem.sv
// AXI3 memory slave: byte-addressable word memory behind independent read and
// write engines, one outstanding transaction each. Supports FIXED/INCR/WRAP
// bursts, WSTRB byte enables, and SLVERR on range or protocol violations.
module axi_slave_mem #(
   parameter int unsigned AXI_ID_WIDTH = 4,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH = 256,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                        clk,
   input  logic                        rstn,
   // write address channel
   input  logic [AXI_ADDR_WIDTH-1:0]   i_awaddr,
   input  logic [AXI_ID_WIDTH-1:0]     i_awid,
   input  logic [3:0]                  i_awlen,
   input  logic [1:0]                  i_awburst,
   input  logic                        i_awvalid,
   output logic                        o_awready,
   // write data channel
   input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
   input  logic [AXI_ID_WIDTH-1:0]     i_wid,
   input  logic [AXI_DATA_WIDTH/8-1:0] i_wstrb,
   input  logic                        i_wlast,
   input  logic                        i_wvalid,
   output logic                        o_wready,
   // write response channel
   output logic [1:0]                  o_bresp,
   output logic [AXI_ID_WIDTH-1:0]     o_bid,
   output logic                        o_bvalid,
   input  logic                        i_bready,
   // read address channel
   input  logic [AXI_ADDR_WIDTH-1:0]   i_araddr,
   input  logic [AXI_ID_WIDTH-1:0]     i_arid,
   input  logic [3:0]                  i_arlen,
   input  logic [1:0]                  i_arburst,
   input  logic                        i_arvalid,
   output logic                        o_arready,
   // read data channel
   output logic [AXI_DATA_WIDTH-1:0]   o_rdata,
   output logic [AXI_ID_WIDTH-1:0]     o_rid,
   output logic [1:0]                  o_rresp,
   output logic                        o_rlast,
   output logic                        o_rvalid,
   input  logic                        i_rready
);

   localparam int unsigned NB   = AXI_DATA_WIDTH / 8;
   localparam int unsigned OFFW = $clog2(NB);
   localparam int unsigned IW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned AW   = AXI_ADDR_WIDTH;

   typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
   typedef enum logic {RIdle, RData} rstate_e;

   // Borrow bit of the subtraction flags addresses below the base.
   function automatic logic in_range(input logic [AW-1:0] addr);
      logic [AW:0]   off;
      logic [AW-1:0] idx;
      off = {1'b0, addr} - {1'b0, BASE_ADDR};
      idx = off[AW-1:0] >> OFFW;
      return !off[AW] && (idx < AW'(MEM_DEPTH));
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] addr);
      return IW'((addr - BASE_ADDR) >> OFFW);
   endfunction

   function automatic logic burst_illegal(input logic [1:0] burst, input logic [3:0] len);
      return (burst == 2'b11) ||
             ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
   endfunction

   // WRAP window is (len+1)*NB bytes; for legal lens that is (len << OFFW) | (NB-1) as a mask.
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [3:0] len,
                                                input logic [1:0] burst);
      logic [AW-1:0] incr;
      logic [AW-1:0] mask;
      logic [AW-1:0] res;
      incr = addr + AW'(NB);
      mask = (AW'(len) << OFFW) | AW'(NB - 1);
      case (burst)
         2'b00:   res = addr;
         2'b10:   res = (addr & ~mask) | (incr & mask);
         default: res = incr;
      endcase
      return res;
   endfunction

   logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // write engine state
   wstate_e                   w_state_q;
   logic                      aw_rdy_q;
   logic                      wready_q;
   logic                      bvalid_q;
   logic [AXI_ID_WIDTH-1:0]   bid_q;
   logic [1:0]                bresp_q;
   logic [AW-1:0]             w_addr_q;
   logic [AXI_ID_WIDTH-1:0]   w_id_q;
   logic [3:0]                w_len_q;
   logic [1:0]                w_burst_q;
   logic [4:0]                w_cnt_q;
   logic                      w_err_q;

   // read engine state
   rstate_e                   r_state_q;
   logic                      ar_rdy_q;
   logic                      rvalid_q;
   logic [AXI_ID_WIDTH-1:0]   rid_q;
   logic [AW-1:0]             r_addr_q;
   logic [3:0]                r_len_q;
   logic [1:0]                r_burst_q;
   logic [3:0]                r_cnt_q;

   logic w_beat;
   logic w_ok;
   logic w_err_next;
   logic mem_we;
   logic r_ok;

   // Per-beat write legality and the error flag as it will stand after this beat.
   always_comb begin
      w_beat     = wready_q && i_wvalid;
      w_ok       = in_range(w_addr_q) && !burst_illegal(w_burst_q, w_len_q) &&
                   (i_wid == w_id_q) && (w_cnt_q <= {1'b0, w_len_q});
      w_err_next = w_err_q || !w_ok || (i_wlast && (w_cnt_q != {1'b0, w_len_q}));
      mem_we     = w_beat && w_ok;
      r_ok       = in_range(r_addr_q) && !burst_illegal(r_burst_q, r_len_q);
   end

   // Ready flags reset high but are masked by rstn so they read 0 during reset
   // and 1 as soon as reset releases.
   assign o_awready = aw_rdy_q && rstn;
   assign o_arready = ar_rdy_q && rstn;
   assign o_wready  = wready_q;
   assign o_bvalid  = bvalid_q;
   assign o_bid     = bid_q;
   assign o_bresp   = bresp_q;
   assign o_rvalid  = rvalid_q;
   assign o_rid     = rid_q;
   assign o_rdata   = (rvalid_q && r_ok) ? mem[word_idx(r_addr_q)] : '0;
   assign o_rresp   = (rvalid_q && !r_ok) ? 2'b10 : 2'b00;
   assign o_rlast   = rvalid_q && (r_cnt_q == r_len_q);

   // Byte-enabled memory write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (i_wstrb[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
   end

   // Write FSM: accept address, consume beats until wlast, then hold the response.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_state_q <= WIdle;
         aw_rdy_q  <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= 2'b00;
         w_addr_q  <= '0;
         w_id_q    <= '0;
         w_len_q   <= '0;
         w_burst_q <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
      end else begin
         unique case (w_state_q)
            WIdle: begin
               if (i_awvalid) begin
                  w_addr_q  <= i_awaddr;
                  w_id_q    <= i_awid;
                  w_len_q   <= i_awlen;
                  w_burst_q <= i_awburst;
                  w_cnt_q   <= '0;
                  w_err_q   <= 1'b0;
                  aw_rdy_q  <= 1'b0;
                  wready_q  <= 1'b1;
                  w_state_q <= WData;
               end
            end
            WData: begin
               if (i_wvalid) begin
                  w_addr_q <= next_addr(w_addr_q, w_len_q, w_burst_q);
                  // saturate past the longest legal burst so overruns stay flagged
                  if (w_cnt_q != 5'd16) w_cnt_q <= w_cnt_q + 5'd1;
                  w_err_q <= w_err_next;
                  if (i_wlast) begin
                     wready_q  <= 1'b0;
                     bvalid_q  <= 1'b1;
                     bid_q     <= w_id_q;
                     bresp_q   <= w_err_next ? 2'b10 : 2'b00;
                     w_state_q <= WResp;
                  end
               end
            end
            WResp: begin
               if (i_bready) begin
                  bvalid_q  <= 1'b0;
                  bid_q     <= '0;
                  bresp_q   <= 2'b00;
                  aw_rdy_q  <= 1'b1;
                  w_state_q <= WIdle;
               end
            end
            default: w_state_q <= WIdle;
         endcase
      end
   end

   // Read FSM: accept address, present one beat per rvalid&rready until the last.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state_q <= RIdle;
         ar_rdy_q  <= 1'b1;
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_burst_q <= '0;
         r_cnt_q   <= '0;
      end else begin
         unique case (r_state_q)
            RIdle: begin
               if (i_arvalid) begin
                  r_addr_q  <= i_araddr;
                  rid_q     <= i_arid;
                  r_len_q   <= i_arlen;
                  r_burst_q <= i_arburst;
                  r_cnt_q   <= '0;
                  ar_rdy_q  <= 1'b0;
                  rvalid_q  <= 1'b1;
                  r_state_q <= RData;
               end
            end
            RData: begin
               if (i_rready) begin
                  if (r_cnt_q == r_len_q) begin
                     rvalid_q  <= 1'b0;
                     rid_q     <= '0;
                     ar_rdy_q  <= 1'b1;
                     r_state_q <= RIdle;
                  end else begin
                     r_cnt_q  <= r_cnt_q + 4'd1;
                     r_addr_q <= next_addr(r_addr_q, r_len_q, r_burst_q);
                  end
               end
            end
         endcase
      end
   end

endmodule
